// File: rtl/mmio_fabric.sv
// mmio_fabric: memory-mapped I/O interconnect between the CPU data port and
// N peripheral slots. Decodes the slot from the byte address, drives a
// one-hot select, waits for the selected slot's ack (bounded by a timeout),
// and returns a one-cycle completion pulse with read data or an error flag.
// Failed accesses are counted (saturating) and their address is logged.
module mmio_fabric #(
    parameter int          N_SLOTS   = 8,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter int          SLOT_BITS = 12,
    parameter int          TIMEOUT   = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 m_addr,
    input  logic [DATA_W-1:0]           m_wdata,
    input  logic                        m_we,
    input  logic                        m_re,
    output logic [DATA_W-1:0]           m_rdata,
    output logic                        m_ready,
    output logic                        m_err,
    output logic [N_SLOTS-1:0]          s_sel,
    output logic                        s_we,
    output logic [SLOT_BITS-1:0]        s_off,
    output logic [DATA_W-1:0]           s_wdata,
    input  logic [N_SLOTS*DATA_W-1:0]   s_rdata,
    input  logic [N_SLOTS-1:0]          s_ack,
    output logic [7:0]                  err_count,
    output logic [31:0]                 err_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        addr_q;
    logic [7:0]         wait_cnt;

    logic [31:0]        req_off;
    logic [31:0]        req_slot;
    logic               req_miss;
    logic [N_SLOTS-1:0] req_onehot;

    logic               ack_hit;
    logic [DATA_W-1:0]  sel_rdata;

    // Address decode of the incoming request: slot offset, slot index and miss detection
    always_comb begin
        req_off  = m_addr - BASE_ADDR;
        req_slot = req_off >> SLOT_BITS;
        req_miss = (m_addr < BASE_ADDR) || (req_slot >= 32'(N_SLOTS));
        for (int k = 0; k < N_SLOTS; k++) begin
            req_onehot[k] = (req_slot == 32'(k));
        end
    end

    // Only the currently selected slot's ack and read word are visible to the FSM
    always_comb begin
        ack_hit   = |(s_ack & s_sel);
        sel_rdata = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (s_sel[k]) begin
                sel_rdata = sel_rdata | s_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Access FSM with registered master/slave outputs and error logging
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            wait_cnt  <= '0;
            m_rdata   <= '0;
            m_ready   <= 1'b0;
            m_err     <= 1'b0;
            s_sel     <= '0;
            s_we      <= 1'b0;
            s_off     <= '0;
            s_wdata   <= '0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    m_ready <= 1'b0;
                    m_err   <= 1'b0;
                    m_rdata <= '0;
                    if (m_we || m_re) begin
                        addr_q <= m_addr;
                        if (req_miss) begin
                            state    <= RESP;
                            m_ready  <= 1'b1;
                            m_err    <= 1'b1;
                            err_addr <= m_addr;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= '0;
                            s_sel    <= req_onehot;
                            s_we     <= m_we;
                            s_off    <= req_off[SLOT_BITS-1:0];
                            s_wdata  <= m_wdata;
                        end
                    end
                end

                WAIT: begin
                    if (ack_hit) begin
                        state   <= RESP;
                        m_ready <= 1'b1;
                        m_err   <= 1'b0;
                        m_rdata <= s_we ? '0 : sel_rdata;
                        s_sel   <= '0;
                        s_we    <= 1'b0;
                        s_off   <= '0;
                        s_wdata <= '0;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        state    <= RESP;
                        m_ready  <= 1'b1;
                        m_err    <= 1'b1;
                        m_rdata  <= '0;
                        s_sel    <= '0;
                        s_we     <= 1'b0;
                        s_off    <= '0;
                        s_wdata  <= '0;
                        err_addr <= addr_q;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                RESP: begin
                    state   <= IDLE;
                    m_ready <= 1'b0;
                    m_err   <= 1'b0;
                    m_rdata <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_fabric.sv
// tb_mmio_fabric: directed bench for mmio_fabric. A transaction-level model
// predicts every cycle of each access from the address map and the slave's
// ack timing; a negedge process compares the DUT against those predictions.
module tb_mmio_fabric;

    localparam int          N_SLOTS   = 8;
    localparam int          DATA_W    = 32;
    localparam logic [31:0] BASE_ADDR = 32'h10010000;
    localparam int          SLOT_BITS = 12;
    localparam int          TIMEOUT   = 15;

    logic                      clk;
    logic                      reset;
    logic [31:0]               m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic                      m_we;
    logic                      m_re;
    logic [DATA_W-1:0]         m_rdata;
    logic                      m_ready;
    logic                      m_err;
    logic [N_SLOTS-1:0]        s_sel;
    logic                      s_we;
    logic [SLOT_BITS-1:0]      s_off;
    logic [DATA_W-1:0]         s_wdata;
    logic [N_SLOTS*DATA_W-1:0] s_rdata;
    logic [N_SLOTS-1:0]        s_ack;
    logic [7:0]                err_count;
    logic [31:0]               err_addr;

    mmio_fabric #(
        .N_SLOTS   (N_SLOTS),
        .DATA_W    (DATA_W),
        .BASE_ADDR (BASE_ADDR),
        .SLOT_BITS (SLOT_BITS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_we      (m_we),
        .m_re      (m_re),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready),
        .m_err     (m_err),
        .s_sel     (s_sel),
        .s_we      (s_we),
        .s_off     (s_off),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata),
        .s_ack     (s_ack),
        .err_count (err_count),
        .err_addr  (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Predicted outputs for the current cycle
    logic                 chk_en;
    logic                 exp_zero;
    logic                 exp_wait;
    logic                 err_chk;
    logic [N_SLOTS-1:0]   exp_sel;
    logic                 exp_we;
    logic [SLOT_BITS-1:0] exp_off;
    logic [DATA_W-1:0]    exp_wdata;
    logic                 exp_ready;
    logic                 exp_err;
    logic [DATA_W-1:0]    exp_rdata;
    int                   model_cnt;
    logic [31:0]          model_eaddr;

    // Observations of the last transaction, used for literal checks
    int                   obs_lat;
    int                   obs_sel_cycles;
    int                   obs_we_cycles;
    logic [SLOT_BITS-1:0] obs_off;
    logic [DATA_W-1:0]    obs_rdata;
    logic                 obs_err;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: compare the DUT against the model's predictions
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("m_ready", 64'(m_ready), 64'(exp_ready));
            checkOutput("s_sel", 64'(s_sel), 64'(exp_sel));
            if (exp_ready || exp_zero) begin
                checkOutput("m_err", 64'(m_err), 64'(exp_err));
                checkOutput("m_rdata", 64'(m_rdata), 64'(exp_rdata));
            end
            if (exp_wait || exp_zero) begin
                checkOutput("s_we", 64'(s_we), 64'(exp_we));
                checkOutput("s_off", 64'(s_off), 64'(exp_off));
                checkOutput("s_wdata", 64'(s_wdata), 64'(exp_wdata));
            end
            if (err_chk) begin
                checkOutput("err_count", 64'(err_count), 64'(model_cnt));
                checkOutput("err_addr", 64'(err_addr), 64'(model_eaddr));
            end
        end
    end

    task automatic setIdleSlaves();
        s_ack = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            s_rdata[k*DATA_W +: DATA_W] = 32'hD00D0000 + 32'(k);
        end
    endtask

    task automatic clearExpect();
        exp_wait  = 1'b0;
        exp_sel   = '0;
        exp_we    = 1'b0;
        exp_off   = '0;
        exp_wdata = '0;
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = '0;
    endtask

    task automatic stepCycle(inout int c, input logic [DATA_W-1:0] wd);
        @(posedge clk);
        #1;
        c++;
        if (m_ready === 1'b1 && obs_lat < 0) begin
            obs_lat   = c;
            obs_rdata = m_rdata;
            obs_err   = m_err;
        end
        if (|s_sel) obs_sel_cycles++;
        if (s_we === 1'b1 && s_wdata === wd) obs_we_cycles++;
        if (c == 1) obs_off = s_off;
    endtask

    // One complete access: ack_after = idle WAIT cycles before ack (-1: never),
    // stray_slot acks every WAIT cycle (-1: none), reset_at aborts in that WAIT cycle (-1: none)
    task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic re,
                                 input logic [31:0] wdata, input int ack_after,
                                 input logic [31:0] ack_data, input int stray_slot,
                                 input int reset_at);
        logic [31:0] off;
        logic [31:0] slot;
        logic        miss;
        logic        ok;
        logic        failed;
        int          n_wait;
        int          c;
        obs_lat = -1; obs_sel_cycles = 0; obs_we_cycles = 0;
        obs_off = '0; obs_rdata = '0; obs_err = 1'b0;
        exp_zero = 1'b0;
        off    = addr - BASE_ADDR;
        slot   = off >> SLOT_BITS;
        miss   = (addr < BASE_ADDR) || (slot >= 32'(N_SLOTS));
        ok     = (ack_after >= 0) && (ack_after < TIMEOUT);
        n_wait = ok ? ack_after + 1 : TIMEOUT;
        m_addr = addr; m_wdata = wdata; m_we = we; m_re = re;
        c = 0;
        if (!miss) begin
            for (int w = 0; w < n_wait; w++) begin
                stepCycle(c, wdata);
                exp_wait  = 1'b1;
                exp_sel   = '0;
                exp_sel[slot[2:0]] = 1'b1;
                exp_we    = we;
                exp_off   = off[SLOT_BITS-1:0];
                exp_wdata = wdata;
                setIdleSlaves();
                s_rdata[slot*DATA_W +: DATA_W] = ~ack_data;
                if (stray_slot >= 0 && 32'(stray_slot) != slot) begin
                    s_ack[stray_slot] = 1'b1;
                end
                if (ok && w == ack_after) begin
                    s_ack[slot[2:0]] = 1'b1;
                    s_rdata[slot*DATA_W +: DATA_W] = ack_data;
                end
                if (w == reset_at) begin
                    reset = 1'b1;
                    m_we = 1'b0; m_re = 1'b0;
                    stepCycle(c, wdata);
                    reset = 1'b0;
                    setIdleSlaves();
                    clearExpect();
                    exp_zero    = 1'b1;
                    model_cnt   = 0;
                    model_eaddr = '0;
                    stepCycle(c, wdata);
                    return;
                end
            end
        end
        stepCycle(c, wdata);
        setIdleSlaves();
        failed    = miss || !ok;
        clearExpect();
        exp_ready = 1'b1;
        exp_err   = failed;
        exp_rdata = (failed || we) ? '0 : ack_data;
        err_chk   = 1'b0;
        if (failed) begin
            if (model_cnt < 255) model_cnt++;
            model_eaddr = addr;
        end
        stepCycle(c, wdata);
        m_we = 1'b0; m_re = 1'b0;
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = '0;
        err_chk   = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        m_addr = '0; m_wdata = '0; m_we = 1'b0; m_re = 1'b0;
        setIdleSlaves();
        clearExpect();
        chk_en = 1'b0; exp_zero = 1'b1; err_chk = 1'b1;
        model_cnt = 0; model_eaddr = '0;
        obs_lat = -1; obs_sel_cycles = 0; obs_we_cycles = 0;
        obs_off = '0; obs_rdata = '0; obs_err = 1'b0;

        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_err_count", 64'(err_count), 64'd0);
        checkOutput("rst_err_addr", 64'(err_addr), 64'd0);

        // Zero-wait read of slot 2
        applyStimulus(32'h10012004, 1'b0, 1'b1, 32'h0, 0, 32'hCAFEF00D, -1, -1);
        checkOutput("rd2_latency", 64'(obs_lat), 64'd2);
        checkOutput("rd2_rdata", 64'(obs_rdata), 64'hCAFEF00D);
        checkOutput("rd2_err", 64'(obs_err), 64'd0);
        checkOutput("rd2_off", 64'(obs_off), 64'h4);

        // Write to slot 0 with three wait states
        applyStimulus(32'h10010010, 1'b1, 1'b0, 32'h55, 3, 32'hFFFFFFFF, -1, -1);
        checkOutput("wr0_latency", 64'(obs_lat), 64'd5);
        checkOutput("wr0_rdata", 64'(obs_rdata), 64'd0);
        checkOutput("wr0_we_cycles", 64'(obs_we_cycles), 64'd4);

        // Decode miss just past the last slot
        applyStimulus(32'h10018000, 1'b0, 1'b1, 32'h0, 0, 32'h0, -1, -1);
        checkOutput("miss_latency", 64'(obs_lat), 64'd1);
        checkOutput("miss_err", 64'(obs_err), 64'd1);
        checkOutput("miss_sel_cycles", 64'(obs_sel_cycles), 64'd0);
        checkOutput("miss_err_addr", 64'(err_addr), 64'h10018000);
        checkOutput("miss_err_count", 64'(err_count), 64'd1);

        // Slot 1 never acks; slot 3 acks throughout and must be ignored
        applyStimulus(32'h10011000, 1'b0, 1'b1, 32'h0, -1, 32'h0, 3, -1);
        checkOutput("tmo_latency", 64'(obs_lat), 64'd16);
        checkOutput("tmo_err", 64'(obs_err), 64'd1);
        checkOutput("tmo_sel_cycles", 64'(obs_sel_cycles), 64'd15);
        checkOutput("tmo_err_count", 64'(err_count), 64'd2);

        // Ack on the final WAIT cycle still succeeds
        applyStimulus(32'h10015020, 1'b0, 1'b1, 32'h0, TIMEOUT - 1, 32'h13579BDF, -1, -1);
        checkOutput("late_latency", 64'(obs_lat), 64'd16);
        checkOutput("late_err", 64'(obs_err), 64'd0);
        checkOutput("late_rdata", 64'(obs_rdata), 64'h13579BDF);

        // Address below the base is a miss
        applyStimulus(32'h1000FFFC, 1'b0, 1'b1, 32'h0, 0, 32'h0, -1, -1);
        checkOutput("low_err_count", 64'(err_count), 64'd3);
        checkOutput("low_err_addr", 64'(err_addr), 64'h1000FFFC);

        // Read and write together behave as a write
        applyStimulus(32'h10016008, 1'b1, 1'b1, 32'h12345678, 0, 32'hBADBADBA, -1, -1);
        checkOutput("both_rdata", 64'(obs_rdata), 64'd0);
        checkOutput("both_we_cycles", 64'(obs_we_cycles), 64'd1);

        // Reset in the third WAIT cycle aborts without a completion
        applyStimulus(32'h10014000, 1'b0, 1'b1, 32'h0, -1, 32'h0, -1, 2);
        checkOutput("rst_no_ready", 64'(obs_lat), 64'(-1));
        checkOutput("rst_mid_count", 64'(err_count), 64'd0);

        // A normal access afterwards, highest offset of slot 7
        applyStimulus(32'h10017FFC, 1'b0, 1'b1, 32'h0, 1, 32'h0BADF00D, -1, -1);
        checkOutput("post_latency", 64'(obs_lat), 64'd3);
        checkOutput("post_rdata", 64'(obs_rdata), 64'h0BADF00D);
        checkOutput("post_off", 64'(obs_off), 64'hFFC);

        // Back-to-back misses saturate the error counter
        for (int i = 0; i < 300; i++) begin
            applyStimulus(32'h20000000 + 32'(i * 4), 1'b0, 1'b1, 32'h0, 0, 32'h0, -1, -1);
        end
        checkOutput("sat_err_count", 64'(err_count), 64'd255);
        checkOutput("sat_err_addr", 64'(err_addr), 64'h200004AC);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
